// File: rtl/id_ex_stage_if.sv
// Signal bundle between the ID/EX stage and its surroundings (IF/ID, register
// file, MEM/WB write ports, fetch control). All vectors are big-endian.
interface id_ex_stage_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 32
);
   logic [0:31]           idInstr;
   logic [0:4]            rfRdAddr0;
   logic [0:4]            rfRdAddr1;
   logic [0:DATA_WIDTH-1] rfRdData0;
   logic [0:DATA_WIDTH-1] rfRdData1;
   logic [0:DATA_WIDTH-1] exResult;
   logic                  memWrEn;
   logic [0:4]            memWrAddr;
   logic [0:DATA_WIDTH-1] memWrData;
   logic                  wbWrEn;
   logic [0:4]            wbWrAddr;
   logic [0:DATA_WIDTH-1] wbWrData;
   logic                  holdIn;
   logic                  exValid;
   logic                  exRegWrEn;
   logic                  exMemRd;
   logic                  exMemWr;
   logic [0:5]            exOpcode;
   logic [0:5]            exFunc;
   logic [0:1]            exWw;
   logic [0:4]            exRd;
   logic [0:15]           exImm;
   logic [0:DATA_WIDTH-1] exOpA;
   logic [0:DATA_WIDTH-1] exOpB;
   logic                  stall;
   logic                  branch;
   logic [0:ADDR_WIDTH-1] branchAddr;

   // Environment side: drives instruction, read data, write ports and hold.
   modport master (
      output idInstr, rfRdData0, rfRdData1, exResult,
      output memWrEn, memWrAddr, memWrData,
      output wbWrEn, wbWrAddr, wbWrData, holdIn,
      input  rfRdAddr0, rfRdAddr1,
      input  exValid, exRegWrEn, exMemRd, exMemWr,
      input  exOpcode, exFunc, exWw, exRd, exImm, exOpA, exOpB,
      input  stall, branch, branchAddr
   );

   // Stage side.
   modport slave (
      input  idInstr, rfRdData0, rfRdData1, exResult,
      input  memWrEn, memWrAddr, memWrData,
      input  wbWrEn, wbWrAddr, wbWrData, holdIn,
      output rfRdAddr0, rfRdAddr1,
      output exValid, exRegWrEn, exMemRd, exMemWr,
      output exOpcode, exFunc, exWw, exRd, exImm, exOpA, exOpB,
      output stall, branch, branchAddr
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX stage: decode, operand forwarding, hazard stall, BEZ/BNEZ resolution and
// the ID/EX register. Optional macro ID_EX_FORWARDING_EN enables the bypass muxes.
module id_ex_stage #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 32
) (
   input logic          clk,
   input logic          reset,
   id_ex_stage_if.slave bus
);

   localparam logic [0:5] OP_ALU  = 6'b101010;
   localparam logic [0:5] OP_LW   = 6'b100000;
   localparam logic [0:5] OP_SW   = 6'b100001;
   localparam logic [0:5] OP_BEZ  = 6'b100010;
   localparam logic [0:5] OP_BNEZ = 6'b100011;
   localparam logic [0:5] OP_NOP  = 6'b111100;

   typedef logic [0:DATA_WIDTH-1] data_t;

   typedef struct packed {
      logic        valid;
      logic        reg_wr_en;
      logic        mem_rd;
      logic        mem_wr;
      logic [0:5]  opcode;
      logic [0:5]  func;
      logic [0:1]  ww;
      logic [0:4]  rd;
      logic [0:15] imm;
      data_t       op_a;
      data_t       op_b;
   } ex_reg_t;

   localparam ex_reg_t EX_RESET = '{
      valid:     1'b0,
      reg_wr_en: 1'b0,
      mem_rd:    1'b0,
      mem_wr:    1'b0,
      opcode:    OP_NOP,
      func:      6'd0,
      ww:        2'd0,
      rd:        5'd0,
      imm:       16'd0,
      op_a:      {DATA_WIDTH{1'b0}},
      op_b:      {DATA_WIDTH{1'b0}}
   };

   ex_reg_t ex_q;
   ex_reg_t ex_d;

   logic [0:5]  id_opcode;
   logic [0:5]  id_func;
   logic [0:4]  id_rd;
   logic [0:4]  id_ra;
   logic [0:4]  id_rb;
   logic [0:1]  id_ww;
   logic [0:15] id_imm;

   assign id_opcode = bus.idInstr[0:5];
   assign id_rd     = bus.idInstr[6:10];
   assign id_ra     = bus.idInstr[11:15];
   assign id_rb     = bus.idInstr[16:20];
   assign id_ww     = bus.idInstr[24:25];
   assign id_func   = bus.idInstr[26:31];
   assign id_imm    = bus.idInstr[16:31];

   logic dec_reg_wr_en;
   logic dec_mem_rd;
   logic dec_mem_wr;
   logic is_alu;
   logic is_bez;
   logic is_bnez;
   logic uses_ab;
   logic uses_d;

   always_comb begin
      dec_reg_wr_en = 1'b0;
      dec_mem_rd    = 1'b0;
      dec_mem_wr    = 1'b0;
      is_alu        = 1'b0;
      is_bez        = 1'b0;
      is_bnez       = 1'b0;
      uses_ab       = 1'b0;
      uses_d        = 1'b0;
      case (id_opcode)
         OP_ALU: begin
            dec_reg_wr_en = 1'b1;
            is_alu        = 1'b1;
            uses_ab       = 1'b1;
         end
         OP_LW: begin
            dec_reg_wr_en = 1'b1;
            dec_mem_rd    = 1'b1;
         end
         OP_SW: begin
            dec_mem_wr = 1'b1;
            uses_d     = 1'b1;
         end
         OP_BEZ: begin
            is_bez = 1'b1;
            uses_d = 1'b1;
         end
         OP_BNEZ: begin
            is_bnez = 1'b1;
            uses_d  = 1'b1;
         end
         default: ;
      endcase
   end

   // Port 0 carries rA for ALU ops and rD for everything else (store data, branch test).
   logic [0:4] src0_addr;
   logic       src0_used;
   logic [0:4] src1_addr;
   logic       src1_used;

   assign src0_addr = is_alu ? id_ra : id_rd;
   assign src0_used = uses_ab | uses_d;
   assign src1_addr = id_rb;
   assign src1_used = uses_ab;

   assign bus.rfRdAddr0 = src0_addr;
   assign bus.rfRdAddr1 = src1_addr;

   data_t op_a;
   data_t op_b;
   logic  hazard;

`ifdef ID_EX_FORWARDING_EN
   // Youngest producer wins; a load in ID/EX has no data yet and is skipped.
   function automatic data_t fwd_operand(input logic [0:4] addr, input data_t rf_data);
      data_t val;
      if (ex_q.reg_wr_en && !ex_q.mem_rd && ex_q.rd == addr) begin
         val = bus.exResult;
      end else if (bus.memWrEn && bus.memWrAddr == addr) begin
         val = bus.memWrData;
      end else if (bus.wbWrEn && bus.wbWrAddr == addr) begin
         val = bus.wbWrData;
      end else begin
         val = rf_data;
      end
      return val;
   endfunction

   always_comb begin
      op_a   = fwd_operand(src0_addr, bus.rfRdData0);
      op_b   = fwd_operand(src1_addr, bus.rfRdData1);
      hazard = ex_q.mem_rd &&
               ((src0_used && ex_q.rd == src0_addr) ||
                (src1_used && ex_q.rd == src1_addr));
   end
`else
   // Without bypassing, any in-flight write to a used source must drain first.
   function automatic logic pending_write(input logic [0:4] addr);
      return (ex_q.reg_wr_en && ex_q.rd == addr) ||
             (bus.memWrEn && bus.memWrAddr == addr) ||
             (bus.wbWrEn && bus.wbWrAddr == addr);
   endfunction

   always_comb begin
      op_a   = bus.rfRdData0;
      op_b   = bus.rfRdData1;
      hazard = (src0_used && pending_write(src0_addr)) ||
               (src1_used && pending_write(src1_addr));
   end

   logic unused_fwd_data;
   assign unused_fwd_data = ^{bus.exResult, bus.memWrData, bus.wbWrData};
`endif

   logic taken;
   logic stall_int;
   logic branch_int;

   always_comb begin
      taken      = (is_bez && op_a == '0) || (is_bnez && op_a != '0);
      stall_int  = reset && (bus.holdIn || hazard);
      branch_int = reset && taken && !stall_int;
   end

   assign bus.stall      = stall_int;
   assign bus.branch     = branch_int;
   assign bus.branchAddr = reset ? {{(ADDR_WIDTH-16){1'b0}}, id_imm} : {ADDR_WIDTH{1'b0}};

   // Hold freezes the register outright; a bubble keeps the data fields.
   always_comb begin
      ex_d = ex_q;
      if (bus.holdIn) begin
         ex_d = ex_q;
      end else if (hazard || taken) begin
         ex_d.valid     = 1'b0;
         ex_d.reg_wr_en = 1'b0;
         ex_d.mem_rd    = 1'b0;
         ex_d.mem_wr    = 1'b0;
         ex_d.opcode    = OP_NOP;
      end else begin
         ex_d.valid     = 1'b1;
         ex_d.reg_wr_en = dec_reg_wr_en;
         ex_d.mem_rd    = dec_mem_rd;
         ex_d.mem_wr    = dec_mem_wr;
         ex_d.opcode    = id_opcode;
         ex_d.func      = id_func;
         ex_d.ww        = id_ww;
         ex_d.rd        = id_rd;
         ex_d.imm       = id_imm;
         ex_d.op_a      = op_a;
         ex_d.op_b      = op_b;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ex_q <= EX_RESET;
      end else begin
         ex_q <= ex_d;
      end
   end

   assign bus.exValid   = ex_q.valid;
   assign bus.exRegWrEn = ex_q.reg_wr_en;
   assign bus.exMemRd   = ex_q.mem_rd;
   assign bus.exMemWr   = ex_q.mem_wr;
   assign bus.exOpcode  = ex_q.opcode;
   assign bus.exFunc    = ex_q.func;
   assign bus.exWw      = ex_q.ww;
   assign bus.exRd      = ex_q.rd;
   assign bus.exImm     = ex_q.imm;
   assign bus.exOpA     = ex_q.op_a;
   assign bus.exOpB     = ex_q.op_b;

endmodule
